hack_boot_loader: RTL and testbench

- Boot sequencer for the Hack CPU.
- Holds the CPU in reset while it receives a program image over an 8-bit valid/ready byte stream, writes each 16-bit word into instruction ROM, and verifies a checksum.
- Releases CPU reset only after a good image has loaded.
- Sits between the host/UART byte source, the instruction ROM write port, and the CPU reset input.

---
 rtl/hack_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_hack_boot_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_boot_loader.sv
// Boot sequencer for the Hack CPU: receives a length-prefixed program image over a byte
// stream, writes it into instruction ROM, verifies an 8-bit checksum, then releases CPU reset.
module hack_boot_loader #(
   parameter int unsigned ROM_DEPTH = 32768,
   parameter bit          AUTO_BOOT = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        rom_we,
   output logic [14:0] rom_addr,
   output logic [15:0] rom_data,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ADDR_W = 15;
   localparam int unsigned WORD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM, ST_RUN, ST_ERROR
   } state_e;

   localparam state_e RESET_STATE = AUTO_BOOT ? ST_LEN_HI : ST_IDLE;

   state_e              state_q, state_d;
   logic [BYTE_W-1:0]   byte_hi_q, byte_hi_d;
   logic [BYTE_W-1:0]   sum_q, sum_d;
   logic [WORD_W-1:0]   len_q, len_d;
   logic [WORD_W-1:0]   wl_q, wl_d;
   logic                rom_we_q, rom_we_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [WORD_W-1:0]   rom_data_q, rom_data_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                accept;

   assign in_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                     (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                     (state_q == ST_CSUM);
   assign accept   = in_valid && in_ready;

   // Next-state, datapath and registered status decode
   always_comb begin
      state_d     = state_q;
      byte_hi_d   = byte_hi_q;
      sum_d       = sum_q;
      len_d       = len_q;
      wl_d        = wl_q;
      rom_we_d    = 1'b0;
      rom_addr_d  = rom_addr_q;
      rom_data_d  = rom_data_q;
      cpu_reset_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;

      // Every accepted byte except the checksum itself feeds the running sum
      if (accept && (state_q != ST_CSUM)) begin
         sum_d = sum_q + in_data;
      end

      case (state_q)
         ST_IDLE, ST_RUN, ST_ERROR: begin
            if (start) begin
               state_d = ST_LEN_HI;
               sum_d   = '0;
               wl_d    = '0;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               byte_hi_d = in_data;
               state_d   = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_d = {byte_hi_q, in_data};
               if (32'(len_d) > ROM_DEPTH) begin
                  state_d = ST_ERROR;
               end else if (len_d == '0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA_HI;
               end
            end
         end
         ST_DATA_HI: begin
            if (accept) begin
               byte_hi_d = in_data;
               state_d   = ST_DATA_LO;
            end
         end
         ST_DATA_LO: begin
            if (accept) begin
               rom_we_d   = 1'b1;
               rom_addr_d = wl_q[ADDR_W-1:0];
               rom_data_d = {byte_hi_q, in_data};
               wl_d       = wl_q + WORD_W'(1);
               state_d    = (wl_d == len_q) ? ST_CSUM : ST_DATA_HI;
            end
         end
         ST_CSUM: begin
            if (accept) begin
               state_d = (in_data == sum_q) ? ST_RUN : ST_ERROR;
            end
         end
         default: state_d = state_q;
      endcase

      case (state_d)
         ST_IDLE: ;
         ST_RUN:  done_d = 1'b1;
         ST_ERROR: begin
            cpu_reset_d = 1'b1;
            error_d     = 1'b1;
         end
         default: begin
            cpu_reset_d = 1'b1;
            busy_d      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RESET_STATE;
         byte_hi_q   <= '0;
         sum_q       <= '0;
         len_q       <= '0;
         wl_q        <= '0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= '0;
         rom_data_q  <= '0;
         cpu_reset_q <= AUTO_BOOT;
         busy_q      <= AUTO_BOOT;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_hi_q   <= byte_hi_d;
         sum_q       <= sum_d;
         len_q       <= len_d;
         wl_q        <= wl_d;
         rom_we_q    <= rom_we_d;
         rom_addr_q  <= rom_addr_d;
         rom_data_q  <= rom_data_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign rom_we       = rom_we_q;
   assign rom_addr     = rom_addr_q;
   assign rom_data     = rom_data_q;
   assign cpu_reset    = cpu_reset_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = wl_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Bench for hack_boot_loader: fixed and random images against a byte-level reference model.
module tb_hack_boot_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready, rom_we, cpu_reset, busy, done, error;
   logic [14:0] rom_addr;
   logic [15:0] rom_data, words_loaded;

   int n_cmp = 0;
   int n_err = 0;

   logic [14:0] wr_addr[$];
   logic [15:0] wr_data[$];
   logic [15:0] img[$];

   // status vector order: cpu_reset, busy, done, error, rom_we, in_ready
   localparam logic [5:0] S_LOADING = 6'b110001;
   localparam logic [5:0] S_RUN     = 6'b001000;
   localparam logic [5:0] S_ERROR   = 6'b100100;

   always #5 clk = ~clk;

   hack_boot_loader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always @(negedge clk) begin
      if (rom_we === 1'b1) begin
         wr_addr.push_back(rom_addr);
         wr_data.push_back(rom_data);
      end
   end

   function automatic logic [5:0] status();
      return {cpu_reset, busy, done, error, rom_we, in_ready};
   endfunction

   task automatic clear_writes();
      wr_addr.delete();
      wr_data.delete();
   endtask

   // Offer one byte with optional random idle gaps and start noise; returns at the negedge after accept
   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise, input bit start_on_accept);
      int guard;
      while (int'($urandom_range(99)) < gap) begin
         in_valid = 1'b0;
         start = noise ? 1'($urandom_range(1)) : 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      start    = start_on_accept | (noise & 1'($urandom_range(1)));
      guard = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL in_ready_timeout: byte %02h never accepted", b);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   // Reference model: serialise img as length, words big-endian, then mod-256 checksum
   task automatic send_image(input int gap, input bit noise, input bit bad);
      logic [7:0] bytes[$];
      logic [7:0] sum;
      int n;
      n = img.size();
      bytes.push_back(8'(n >> 8));
      bytes.push_back(8'(n));
      foreach (img[i]) begin
         bytes.push_back(img[i][15:8]);
         bytes.push_back(img[i][7:0]);
      end
      sum = 8'h00;
      foreach (bytes[i]) sum = sum + bytes[i];
      foreach (bytes[i]) send_byte(bytes[i], gap, noise, 1'b0);
      send_byte(bad ? sum + 8'h01 : sum, gap, noise, noise);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #2;
      n_cmp++;
      if (status() !== S_LOADING) begin
         n_err++;
         $display("FAIL reset_status: got %06b exp %06b", status(), S_LOADING);
      end
      n_cmp++;
      if (rom_addr !== 15'd0 || rom_data !== 16'd0 || words_loaded !== 16'd0) begin
         n_err++;
         $display("FAIL reset_regs: addr %0h data %0h wl %0d exp 0 0 0", rom_addr, rom_data, words_loaded);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_good_image();
      logic [7:0] bytes [9];
      bytes = '{8'h00, 8'h03, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hE3, 8'h08, 8'hEC};
      img = '{16'h0002, 16'hEC10, 16'hE308};
      clear_writes();
      for (int i = 0; i < 9; i++) begin
         send_byte(bytes[i], 0, 1'b0, 1'b0);
         if (i == 3) begin
            n_cmp++;
            if (rom_we !== 1'b1 || rom_addr !== 15'd0 || rom_data !== 16'h0002) begin
               n_err++;
               $display("FAIL good_first_write: we %0b addr %0h data %04h exp 1 0 0002", rom_we, rom_addr, rom_data);
            end
         end
      end
      #1;
      n_cmp++;
      if (wr_addr.size() != 3) begin
         n_err++;
         $display("FAIL good_write_count: got %0d exp 3", wr_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 15'(i) || wr_data[i] !== img[i]) begin
               n_err++;
               $display("FAIL good_write_%0d: addr %0h data %04h exp %0h %04h", i, wr_addr[i], wr_data[i], i, img[i]);
            end
         end
      end
      n_cmp++;
      if (status() !== S_RUN || words_loaded !== 16'd3) begin
         n_err++;
         $display("FAIL good_final: status %06b wl %0d exp %06b 3", status(), words_loaded, S_RUN);
      end
   endtask

   task automatic test_bad_csum();
      do_start();
      n_cmp++;
      if (status() !== S_LOADING || words_loaded !== 16'd0) begin
         n_err++;
         $display("FAIL restart_status: status %06b wl %0d exp %06b 0", status(), words_loaded, S_LOADING);
      end
      img = '{16'h0002, 16'hEC10, 16'hE308};
      clear_writes();
      send_image(0, 1'b0, 1'b1);
      n_cmp++;
      if (status() !== S_ERROR) begin
         n_err++;
         $display("FAIL bad_csum_status: got %06b exp %06b", status(), S_ERROR);
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (wr_addr.size() != 3 || status() !== S_ERROR) begin
         n_err++;
         $display("FAIL bad_csum_hold: writes %0d status %06b exp 3 %06b", wr_addr.size(), status(), S_ERROR);
      end
   endtask

   task automatic test_empty();
      do_start();
      img.delete();
      clear_writes();
      send_image(0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (wr_addr.size() != 0 || status() !== S_RUN || words_loaded !== 16'd0) begin
         n_err++;
         $display("FAIL empty: writes %0d status %06b wl %0d exp 0 %06b 0", wr_addr.size(), status(), words_loaded, S_RUN);
      end
   endtask

   task automatic test_oversize();
      do_start();
      clear_writes();
      send_byte(8'h80, 0, 1'b0, 1'b0);
      send_byte(8'h01, 0, 1'b0, 1'b0);
      n_cmp++;
      if (status() !== S_ERROR || wr_addr.size() != 0) begin
         n_err++;
         $display("FAIL oversize: status %06b writes %0d exp %06b 0", status(), wr_addr.size(), S_ERROR);
      end
      do_start();
      send_byte(8'h80, 0, 1'b0, 1'b0);
      send_byte(8'h00, 0, 1'b0, 1'b0);
      n_cmp++;
      if (status() !== S_LOADING) begin
         n_err++;
         $display("FAIL max_length_accepted: status %06b exp %06b", status(), S_LOADING);
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int it = 0; it < 4; it++) begin
         img.delete();
         for (int w = 0; w < int'($urandom_range(6, 1)); w++) img.push_back(16'($urandom));
         clear_writes();
         send_image(40, 1'b1, 1'b0);
         #1;
         n_cmp++;
         if (wr_addr.size() != img.size()) begin
            n_err++;
            $display("FAIL b2b_count_%0d: got %0d exp %0d", it, wr_addr.size(), img.size());
         end else begin
            foreach (img[i]) begin
               n_cmp++;
               if (wr_addr[i] !== 15'(i) || wr_data[i] !== img[i]) begin
                  n_err++;
                  $display("FAIL b2b_write_%0d_%0d: addr %0h data %04h exp %0h %04h", it, i, wr_addr[i], wr_data[i], i, img[i]);
               end
            end
         end
         n_cmp++;
         if (status() !== S_RUN || words_loaded !== 16'(img.size())) begin
            n_err++;
            $display("FAIL b2b_final_%0d: status %06b wl %0d exp %06b %0d", it, status(), words_loaded, S_RUN, img.size());
         end
         @(negedge clk);
         if (it < 3) begin
            do_start();
            n_cmp++;
            if (status() !== S_LOADING || words_loaded !== 16'd0) begin
               n_err++;
               $display("FAIL b2b_restart_%0d: status %06b wl %0d exp %06b 0", it, status(), words_loaded, S_LOADING);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_start();
      img.delete();
      for (int w = 0; w < 4; w++) img.push_back(16'($urandom));
      clear_writes();
      send_byte(8'h00, 0, 1'b0, 1'b0);
      send_byte(8'h04, 0, 1'b0, 1'b0);
      for (int w = 0; w < 2; w++) begin
         send_byte(img[w][15:8], 0, 1'b0, 1'b0);
         send_byte(img[w][7:0], 0, 1'b0, 1'b0);
      end
      send_byte(img[2][15:8], 0, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (status() !== S_LOADING || rom_addr !== 15'd0 || rom_data !== 16'd0 || words_loaded !== 16'd0) begin
         n_err++;
         $display("FAIL async_reset: status %06b addr %0h data %04h wl %0d exp %06b 0 0 0", status(), rom_addr, rom_data, words_loaded, S_LOADING);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (wr_addr.size() != 2) begin
         n_err++;
         $display("FAIL async_partial: writes %0d exp 2", wr_addr.size());
      end
      @(negedge clk);
      clear_writes();
      send_image(20, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (wr_addr.size() != 4) begin
         n_err++;
         $display("FAIL reload_count: got %0d exp 4", wr_addr.size());
      end else begin
         foreach (img[i]) begin
            n_cmp++;
            if (wr_addr[i] !== 15'(i) || wr_data[i] !== img[i]) begin
               n_err++;
               $display("FAIL reload_write_%0d: addr %0h data %04h exp %0h %04h", i, wr_addr[i], wr_data[i], i, img[i]);
            end
         end
      end
      n_cmp++;
      if (status() !== S_RUN || words_loaded !== 16'd4) begin
         n_err++;
         $display("FAIL reload_final: status %06b wl %0d exp %06b 4", status(), words_loaded, S_RUN);
      end
   endtask

   initial begin
      test_reset();
      test_good_image();
      test_bad_csum();
      test_empty();
      test_oversize();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
